// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the MEM pipeline stage and a word-organised data memory. One
//   load/store request is accepted at a time over a valid/ready handshake.
//   Byte addresses become a word address plus byte enables. Accesses that
//   cross a word boundary are split into two memory beats. Load data is
//   returned sign- or zero-extended. The memory read path is combinational,
//   and writes commit on the posedge that ends a beat.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_funct3          store flag, RV32I width/sign code
//   req_addr, req_wdata         byte address, store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data, illegal-access flag
//   mem_addr, mem_wdata         word address, lane-shifted store data
//   mem_be, mem_we              byte-lane enables, write strobe
//   mem_rdata                   combinational read data for mem_addr
module load_store_unit #(
    parameter int ADDR_W           = 6,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic              err_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q, hi_q;

    // Only the word and byte-offset bits reach the memory. The upper
    // address bits are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // A halfword at offset 3, or a word at any nonzero offset, spills into the next word.
    function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'd1 && off == 2'd3) || (f3[1:0] == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        else    return f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
    endfunction

    logic accept, req_err;
    assign accept  = req_valid && (state == IDLE);
    // When splitting is disabled, "misaligned" means word-crossing. An
    // access that stays inside one word is always serviced.
    assign req_err = !legal(req_we, req_funct3) ||
                     (!ALLOW_MISALIGNED && crosses(req_funct3, req_addr[1:0]));

    // NOTE: state and registers update with <= so every flop samples
    // pre-edge values, regardless of the order of the blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: request and lane buffers are not reset. Every output that
    // exposes them is gated by state, and state itself is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
            err_q    <= req_err;
        end
        if (state == BEAT0 && !we_q) lo_q <= mem_rdata;
        if (state == BEAT1 && !we_q) hi_q <= mem_rdata;
    end

    // Lane geometry of the latched request.
    logic [1:0]        off;
    logic [ADDR_W-1:0] word;
    logic [7:0]        be_base, be_full;
    logic [31:0]       wdata_lo, wdata_hi;
    logic [31:0]       ld_aligned, ld_ext;

    assign off  = addr_q[1:0];
    assign word = addr_q[ADDR_W+1:2];

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    be_base = 8'b0000_0001;
            2'd1:    be_base = 8'b0000_0011;
            default: be_base = 8'b0000_1111;
        endcase
    end
    assign be_full  = be_base << off;
    assign wdata_lo = wdata_q << {off, 3'b000};
    // BEAT1 only occurs with off != 0, so the shift stays in the range 8..24.
    assign wdata_hi = wdata_q >> (6'd32 - {1'b0, off, 3'b000});

    assign ld_aligned = 32'({hi_q, lo_q} >> {off, 3'b000});
    always_comb begin
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_aligned[7]}},  ld_aligned[7:0]};
            3'd1:    ld_ext = {{16{ld_aligned[15]}}, ld_aligned[15:0]};
            3'd4:    ld_ext = {24'd0, ld_aligned[7:0]};
            3'd5:    ld_ext = {16'd0, ld_aligned[15:0]};
            default: ld_ext = ld_aligned;
        endcase
    end

    // NOTE: every signal gets a default before the case statement, so no
    // path through this block can infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_addr = word;
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_be    = be_full[3:0];
                    mem_wdata = wdata_lo;
                end
                state_nxt = crosses(funct3_q, off) ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_addr = word + ADDR_W'(1);
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_be    = be_full[7:4];
                    mem_wdata = wdata_hi;
                end
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !we_q) rsp_rdata = ld_ext;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed test of load_store_unit against a 64-word byte-enabled memory
//   model. Expected values are worked out by hand from the request
//   encoding.
module tb_load_store_unit;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0, req_wdata = 32'd0;
    logic              req_ready, rsp_valid, rsp_err, mem_we;
    logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-enabled memory with combinational read.
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (mem_we)
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
    assign mem_rdata = mem[mem_addr];

    // A record of every memory beat, meaning each cycle that is outside IDLE and RESP.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic              we;
    } beat_t;
    beat_t beat_q[$];

    always @(negedge clk) begin
        if (rst && !req_ready && !rsp_valid)
            beat_q.push_back({mem_addr, mem_be, mem_wdata, mem_we});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [ADDR_W-1:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata, input logic we);
        beat_t b;
        b = (idx < beat_q.size()) ? beat_q[idx] : '0;
        check({tag, " addr"}, 32'(b.addr), 32'(addr));
        check({tag, " be"},   32'(b.be),   32'(be));
        check({tag, " we"},   32'(b.we),   32'(we));
        if (we) check({tag, " wdata"}, b.wdata, wdata);
    endtask

    // Issue one request starting at a negedge in IDLE. Measure the latency
    // to rsp_valid, check the response, hold it for `hold` cycles, then
    // complete the handshake.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input int exp_beats,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold, output int first);
        int lat;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        first      = beat_q.size();
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " beats"}, 32'(beat_q.size() - first), 32'(exp_beats));
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " held err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, " held rdata"}, rsp_rdata, exp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " released"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        check("reset rsp_rdata", rsp_rdata,      32'd0);
        check("reset mem_be",    32'(mem_be),    32'd0);
        check("reset mem_we",    32'(mem_we),    32'd0);
        check("reset mem_addr",  32'(mem_addr),  32'd0);
        check("reset mem_wdata", mem_wdata,      32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Aligned word store and load.
        xact("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 1, 32'd0, 0, 0, f);
        check_beat("sw10 b0", f, 6'd4, 4'b1111, 32'hDEADBEEF, 1);
        xact("lw10", 0, 3'd2, 32'h10, 32'd0, 2, 1, 32'hDEADBEEF, 0, 0, f);
        check_beat("lw10 b0", f, 6'd4, 4'b0000, 32'd0, 0);

        // Byte store to lane 3. Signed and unsigned byte loads.
        xact("sb13", 1, 3'd0, 32'h13, 32'h80, 2, 1, 32'd0, 0, 0, f);
        check_beat("sb13 b0", f, 6'd4, 4'b1000, 32'h80000000, 1);
        xact("lb13",  0, 3'd0, 32'h13, 32'd0, 2, 1, 32'hFFFFFF80, 0, 0, f);
        xact("lbu13", 0, 3'd4, 32'h13, 32'd0, 2, 1, 32'h00000080, 0, 0, f);

        // Word load split across words 4 and 5.
        xact("sw10b", 1, 3'd2, 32'h10, 32'h44332211, 2, 1, 32'd0, 0, 0, f);
        xact("sw14",  1, 3'd2, 32'h14, 32'h88776655, 2, 1, 32'd0, 0, 0, f);
        xact("lw13",  0, 3'd2, 32'h13, 32'd0, 3, 2, 32'h77665544, 0, 0, f);
        check_beat("lw13 b0", f,     6'd4, 4'b0000, 32'd0, 0);
        check_beat("lw13 b1", f + 1, 6'd5, 4'b0000, 32'd0, 0);
        xact("lh12", 0, 3'd1, 32'h12, 32'd0, 2, 1, 32'h00004433, 0, 0, f);

        // Halfword store split across words 5 and 6, then read back.
        xact("sh17", 1, 3'd1, 32'h17, 32'h0000A1B2, 3, 2, 32'd0, 0, 0, f);
        check_beat("sh17 b0", f,     6'd5, 4'b1000, 32'hB2000000, 1);
        check_beat("sh17 b1", f + 1, 6'd6, 4'b0001, 32'h000000A1, 1);
        xact("lhu17", 0, 3'd5, 32'h17, 32'd0, 3, 2, 32'h0000A1B2, 0, 0, f);
        xact("lh17",  0, 3'd1, 32'h17, 32'd0, 3, 2, 32'hFFFFA1B2, 0, 0, f);

        // Illegal funct3: error response, no memory beats, held while stalled.
        xact("ld_f3", 0, 3'd3, 32'h10, 32'd0, 1, 0, 32'd0, 1, 5, f);
        xact("st_f3", 1, 3'd3, 32'h10, 32'hFFFFFFFF, 1, 0, 32'd0, 1, 0, f);
        xact("lw10c", 0, 3'd2, 32'h10, 32'd0, 2, 1, 32'h44332211, 0, 0, f);

        // The top word wraps to word 0. The upper address bits are ignored.
        xact("sw_fc", 1, 3'd2, 32'hFC, 32'hCCBBAA99, 2, 1, 32'd0, 0, 0, f);
        xact("sw_00", 1, 3'd2, 32'h00, 32'h00FFEEDD, 2, 1, 32'd0, 0, 0, f);
        xact("lw_ff", 0, 3'd2, 32'hFFFFFFFF, 32'd0, 3, 2, 32'hFFEEDDCC, 0, 0, f);
        check_beat("lw_ff b0", f,     6'd63, 4'b0000, 32'd0, 0);
        check_beat("lw_ff b1", f + 1, 6'd0,  4'b0000, 32'd0, 0);

        // Reset while the response is pending.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstresp valid before", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("rstresp rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstresp req_ready", 32'(req_ready), 32'd1);
        check("rstresp mem_be",    32'(mem_be),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstresp after valid", 32'(rsp_valid), 32'd0);
        check("rstresp after ready", 32'(req_ready), 32'd1);

        // Reset during BEAT1 of a split store: BEAT0 stays committed, BEAT1 never writes.
        xact("sw20", 1, 3'd2, 32'h20, 32'h000000AA, 2, 1, 32'd0, 0, 0, f);
        xact("sw24", 1, 3'd2, 32'h24, 32'h55555555, 2, 1, 32'd0, 0, 0, f);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h21; req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b0;
        check("sw21 b0 addr",  32'(mem_addr), 32'd8);
        check("sw21 b0 be",    32'(mem_be),   32'hE);
        check("sw21 b0 wdata", mem_wdata,     32'h22334400);
        @(posedge clk);
        #1;
        check("sw21 b1 addr",  32'(mem_addr), 32'd9);
        check("sw21 b1 be",    32'(mem_be),   32'h1);
        check("sw21 b1 wdata", mem_wdata,     32'h00000011);
        rst = 1'b0;
        #1;
        check("sw21 rst we",    32'(mem_we),    32'd0);
        check("sw21 rst ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xact("lw20", 0, 3'd2, 32'h20, 32'd0, 2, 1, 32'h223344AA, 0, 0, f);
        xact("lw24", 0, 3'd2, 32'h24, 32'd0, 2, 1, 32'h55555555, 0, 0, f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
